// File: rtl/serial_io_pkg.sv
// serial_io_pkg: shared state encoding and counter sizing for the serial I/O chain driver.
package serial_io_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/serial_io_chain_tick_gen.sv
// tick_gen: modulo-N counter with synchronous clear; tick is high while the count sits at N-1.
module tick_gen
   import serial_io_pkg::*;
#(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   logic [CW-1:0] cnt;
   assign tick = cnt == LAST;
   always_ff @(posedge clk) begin
      if (!rst_n || clr) cnt <= '0;
      else cnt <= tick ? '0 : cnt + CW'(1);
   end
endmodule

// File: rtl/serial_io_chain.sv
// serial_io_chain: frame driver for chained 74HC595 outputs and 74HC165 inputs on a shared serial clock.
module serial_io_chain
   import serial_io_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CLK_DIV   = 1024,
   parameter int REFRESH   = 1048576,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             start,
   input  logic             auto_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rx_data,
   output logic             sclk,
   output logic             sdata,
   input  logic             sdatain,
   output logic             sdata_pl,
   output logic             slatch
);
   localparam int BW = cnt_w(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   logic [1:0] state;
   logic [WIDTH-1:0] tx_sr, rx_sr, tx_next;
   logic [BW-1:0] bit_cnt;
   logic pending, tick, ref_tick, auto_req, accept;
   assign auto_req = ref_tick & auto_en;
   // the done cycle still counts as busy, so nothing is accepted until the cycle after it
   assign accept = (state == ST_IDLE) && !done && (start || pending || auto_req);
   assign busy = (state != ST_IDLE) || done;
   assign tx_next = MSB_FIRST ? tx_sr << 1 : tx_sr >> 1;
   tick_gen #(.N(CLK_DIV)) u_div (.clk(clk), .rst_n(rst_n), .clr(accept), .tick(tick));
   tick_gen #(.N(REFRESH)) u_ref (.clk(clk), .rst_n(rst_n), .clr(1'b0), .tick(ref_tick));
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         bit_cnt  <= '0;
         pending  <= 1'b0;
         sclk     <= 1'b0;
         sdata    <= 1'b0;
         sdata_pl <= 1'b0;
         slatch   <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
      end else begin
         done    <= 1'b0;
         pending <= !accept && (pending || auto_req);
         case (state)
            ST_IDLE: if (accept) begin
               tx_sr    <= tx_data;
               sdata    <= MSB_FIRST ? tx_data[WIDTH-1] : tx_data[0];
               sdata_pl <= 1'b1;
               state    <= ST_LOAD;
            end
            ST_LOAD: if (tick) begin
               sclk    <= 1'b0;
               bit_cnt <= '0;
               state   <= ST_SHIFT;
            end
            ST_SHIFT: if (tick) begin
               if (!sclk) begin
                  sclk  <= 1'b1;
                  rx_sr <= MSB_FIRST ? (rx_sr << 1) | WIDTH'(sdatain)
                                     : (rx_sr >> 1) | (WIDTH'(sdatain) << (WIDTH - 1));
               end else begin
                  sclk <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     sdata_pl <= 1'b0;
                     slatch   <= 1'b1;
                     state    <= ST_LATCH;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     tx_sr   <= tx_next;
                     sdata   <= MSB_FIRST ? tx_next[WIDTH-1] : tx_next[0];
                  end
               end
            end
            ST_LATCH: if (tick) begin
               slatch  <= 1'b0;
               rx_data <= rx_sr;
               done    <= 1'b1;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/serial_io_chain.md
Name: serial_io_chain

Overview:
- Parametrised synchronous driver for chained 74HC595 (output) and 74HC165 (input) shift registers sharing one serial clock.
- Shifts WIDTH bits out and WIDTH bits in per frame. Frames start on request or from an internal refresh timer.
- Everything runs in the clk domain: no derived clocks, only divider tick enables.
- Sits between SoC I/O registers (LEDs, buttons) and the board pins.

Parameters:
- WIDTH, 16, bits per frame (total chained register width, >=1)
- CLK_DIV, 1024, clk cycles per serial half-period (>=2)
- REFRESH, 1048576, clk cycles between automatic frames (> (2*WIDTH+2)*CLK_DIV)
- MSB_FIRST, 0, 1: bit WIDTH-1 is shifted first in both directions; 0: bit 0 first

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tx_data  in  WIDTH  parallel data to shift out; captured at frame start
- start  in  1  frame request, sampled while idle
- auto_en  in  1  enables refresh-timer frames
- busy  out  1  high from frame accept until the done cycle inclusive
- done  out  1  one-cycle pulse at frame end
- rx_data  out  WIDTH  last completed received frame
- sclk  out  1  serial clock to both chains
- sdata  out  1  serial data to the 595 chain
- sdatain  in  1  serial data from the 165 chain
- sdata_pl  out  1  165 parallel-load control; low = load/hold, high = shift
- slatch  out  1  595 storage-register latch pulse

Behaviour:
- Reset (rst_n low at a clk edge): sclk=0, sdata=0, sdata_pl=0, slatch=0, busy=0, done=0, rx_data=0. All counters, pending flag and state are cleared. Reset mid-frame aborts the frame with no done pulse.
- Tick: the divider counts 0..CLK_DIV-1 and pulses a tick at CLK_DIV-1. It is cleared on frame accept, so the first tick comes CLK_DIV cycles after accept.
- Refresh counter: free-running 0..REFRESH-1, independent of frames. Wrap with auto_en=1 is an auto request.
- States: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - On start=1 or a pending/auto request: capture tx_data into the tx shift register, set busy=1, go to LOAD.
  - Simultaneous start and auto request launch exactly one frame and clear pending.
- LOAD:
  - sdata_pl=1 and sdata = first bit; held for one half-period.
  - On tick go to SHIFT with sclk=0, bit counter 0.
- SHIFT:
  - Tick with sclk=0: sclk goes to 1 and sdatain is sampled into the rx shift register on the same edge.
  - Tick with sclk=1: sclk goes to 0.
    - If bit counter = WIDTH-1: go to LATCH, sdata_pl=0, slatch=1.
    - Otherwise increment the counter and present the next tx bit on sdata.
- LATCH: slatch held high for one half-period. On tick:
  - slatch=0
  - rx_data updated from the rx shift register, bit-ordered per MSB_FIRST
  - done=1 for one cycle, busy=0 in the following cycle, return to IDLE
- Latency: done is asserted exactly (2*WIDTH+2)*CLK_DIV cycles after the accept edge. A new frame may be accepted the cycle after done.
- start while busy is ignored.
- Auto request while busy sets a one-deep pending flag, launched on return to IDLE. Further auto requests while pending are dropped.
- Bit order: with MSB_FIRST=0 the k-th sclk rise carries tx_data[k] and stores sdatain into rx_data[k]. With MSB_FIRST=1 index WIDTH-1-k is used instead.
- tx_data changes during a frame have no effect.
- rx_data holds its value between frames.

Decomposition:
- Package serial_io_pkg: state encoding constants (IDLE, LOAD, SHIFT, LATCH) and the counter-width function for CLK_DIV/REFRESH/WIDTH.
- One sub-module, tick_gen: parametrised modulo-N counter with synchronous clear and tick output. Instantiated twice: serial half-period (clear on accept) and refresh (never cleared except by reset).

Test Plan:
- Bench settings: WIDTH=16, CLK_DIV=4, REFRESH=256.
- Reset: hold rst_n=0 three cycles with start=1 -> all outputs 0, no frame starts until rst_n=1.
- Output shift: start pulse with tx_data=16'hA5C3, MSB_FIRST=0 -> sdata at successive sclk rises 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; slatch pulse of 4 cycles after the 16th fall; done at cycle 136 after accept.
- Input shift: 165 model loaded with 16'h3C5A while sdata_pl=0 -> rx_data=16'h3C5A at done; MSB_FIRST=1 build gives the same rx_data value, with the 165 model presenting bit 15 first.
- Auto mode: auto_en=1, no start -> frames accepted every 256 cycles; a start pulse mid-frame is ignored, so the frame count is unchanged.
- Pending: CLK_DIV=4, REFRESH=140, with a start issued 10 cycles before the refresh wrap -> auto request held pending, next frame accepted the cycle after done returns to IDLE, exactly one extra frame.
- Mid-frame reset: rst_n=0 during the 8th bit -> next edge sclk=0, sdata_pl=0, busy=0, rx_data=0, no done pulse; a fresh start afterwards completes normally.
